autocorrelation_feeder: RTL and testbench
=========================================

# autocorrelation_feeder

Frame-buffered sample sequencer that drives the `autocorrelation_mad` multiply-accumulate unit. It accepts one frame of PCM samples, then for each lag k = 0..ORDER it clears the MAD and streams the pairs (x[n], x[n-k]), n = k..FRAME_LEN-1. It pulses `lag_done` when the MAD accumulator holds R[k]; downstream LPC logic captures `y` on that pulse.

## Interface
- FRAME_LEN, 160: samples per frame; must be > ORDER.
- ORDER, 10: highest lag computed; lags 0..ORDER.
- MAD_LAT, 2: cycles from a pair on `x`/`x_lagged` until it is reflected in MAD `y`.
- ADDR_W, 8: buffer address width; 2^ADDR_W >= FRAME_LEN.
- LAG_W, 4: lag index width; 2^LAG_W > ORDER.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- sample_in  in  16  signed two's-complement input sample
- sample_valid  in  1  `sample_in` valid this cycle
- sample_ready  out  1  feeder accepting samples (LOAD state)
- x  out  16  signed current sample to MAD
- x_lagged  out  16  signed lagged sample to MAD
- pair_valid  out  1  `x`/`x_lagged` carry a real pair
- mad_clear  out  1  one-cycle accumulator clear; wired to MAD `reset`, ORed with system reset at top level
- lag_idx  out  LAG_W  lag currently streamed/reported
- lag_done  out  1  one-cycle pulse: MAD `y` = R[lag_idx] this cycle
- frame_done  out  1  one-cycle pulse coincident with `lag_done` for lag ORDER

## Operation
- Storage: FRAME_LEN x 16 register array, one write port, two read ports. Reset does not clear contents.
- FSM states: LOAD, CLEAR, STREAM, DRAIN.
- LOAD: `sample_ready`=1. A sample is written when `sample_valid` && `sample_ready`, at `wr_ptr`, then `wr_ptr`++. A gap in `sample_valid` stalls without side effects. Accepting sample FRAME_LEN-1 goes to CLEAR with lag=0, and `sample_ready` drops the next cycle.
- CLEAR: one cycle. Sets n=lag. Outputs `mad_clear`=1 on the following cycle.
- STREAM: each cycle emits buf[n] on `x`, buf[n-lag] on `x_lagged`, `pair_valid`=1, then n++. After n=FRAME_LEN-1, goes to DRAIN. Pairs per lag = FRAME_LEN-lag.
- DRAIN: counts MAD_LAT cycles, then pulses `lag_done`.
  - If lag==ORDER: also pulses `frame_done` and returns to LOAD with `wr_ptr`=0.
  - Otherwise: lag++ and goes to CLEAR.
- Whenever `pair_valid`=0, `x`=`x_lagged`=0, so the enable-less MAD accumulates 0.
- `sample_valid` outside LOAD is ignored. Samples are never dropped while `sample_ready`=1.
- No arithmetic on data. Samples pass through bit-exact, and sign is preserved.

## Timing
- All outputs are registered. Reset values: `sample_ready`=1 the cycle after reset deasserts; `x`=0, `x_lagged`=0, `pair_valid`=0, `mad_clear`=0, `lag_idx`=0, `lag_done`=0, `frame_done`=0.
- Cycle C = the cycle `mad_clear`=1 for lag k.
  - Pairs occupy C+1 .. C+(FRAME_LEN-k).
  - `lag_done` is at C+(FRAME_LEN-k)+MAD_LAT.
  - The next `mad_clear` is at `lag_done`+1 (the CLEAR cycle overlaps the `lag_done` output cycle).
- Per-lag period = 1+(FRAME_LEN-k)+MAD_LAT cycles.
- First `mad_clear` is 1 cycle after the last sample is accepted.
- `lag_idx` is stable from `mad_clear` through `lag_done` of the same lag.
- `sample_ready` reasserts the cycle after `frame_done`.
- Reset mid-frame, in any state: the next cycle is LOAD with `wr_ptr`=0, lag=0, and all outputs at reset values. A partial frame is discarded and no `lag_done` is issued.
- Reset coincident with a `sample_valid` handshake: reset wins and the sample is not counted.

## Test plan
- Small frame, FRAME_LEN=4, ORDER=2, MAD_LAT=2, samples 1,2,3,4, MAD attached:
  - Pairs (1,1)(2,2)(3,3)(4,4) -> `y`=30 at `lag_done`, lag 0.
  - (2,1)(3,2)(4,3) -> 20.
  - (3,1)(4,2) -> 11, with `frame_done`.
  - Lag periods are 7, 6 and 5 cycles.
- Signed data: samples -835,-58,-685,-931 (FRAME_LEN=4, ORDER=1):
  - `x`/`x_lagged` are bit-exact.
  - R[1] = 48430+39730+637735 = 725895.
- Backpressure: `sample_valid` toggled 1,0,0,1,... -> exactly FRAME_LEN writes, no `sample_ready` drop before the last sample, first `mad_clear` 1 cycle after the last accept.
- Reset during STREAM of lag 1 -> next cycle `pair_valid`=0, `x`=0, `sample_ready`=1, `lag_idx`=0, no `lag_done`; a new frame then computes correctly.
- Default params (160/10/2): 11 `lag_done` pulses with `lag_idx` 0..10, 1738 cycles from first `mad_clear` to `frame_done`, R[k] matches a software reference.
- Back-to-back frames: `sample_valid` held high through compute -> no sample accepted outside LOAD, second frame results independent of the first.

Source files
------------

// File: rtl/autocorrelation_feeder.sv
// rtl/autocorrelation_feeder.sv - frame buffer and lag sequencer that feeds the autocorrelation MAD
//
// Buffers one frame of PCM samples, then for each lag k = 0..ORDER clears the
// MAD and streams the pairs (x[n], x[n-k]) for n = k..FRAME_LEN-1.
//
// Ports:
//   clk_i           rising-edge clock
//   reset_i         synchronous active-high reset
//   sample_in_i     signed input sample
//   sample_valid_i  sample_in_i valid this cycle
//   sample_ready_o  feeder is loading a frame
//   x_o             current sample to MAD (0 when no pair)
//   x_lagged_o      lagged sample to MAD (0 when no pair)
//   pair_valid_o    x_o / x_lagged_o carry a real pair
//   mad_clear_o     one-cycle MAD accumulator clear
//   lag_idx_o       lag being streamed / reported
//   lag_done_o      MAD y holds R[lag_idx_o] this cycle
//   frame_done_o    lag_done_o for the final lag
module autocorrelation_feeder #(
    parameter int FRAME_LEN = 160,
    parameter int ORDER     = 10,
    parameter int MAD_LAT   = 2,
    parameter int ADDR_W    = 8,
    parameter int LAG_W     = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [15:0]       sample_in_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic [15:0]       x_o,
    output logic [15:0]       x_lagged_o,
    output logic              pair_valid_o,
    output logic              mad_clear_o,
    output logic [LAG_W-1:0]  lag_idx_o,
    output logic              lag_done_o,
    output logic              frame_done_o
);

    localparam int CNT_W = $clog2(MAD_LAT + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [LAG_W-1:0]  ORDER_C  = LAG_W'(ORDER);
    localparam logic [CNT_W-1:0]  LAT_C    = CNT_W'(MAD_LAT);

    typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_STREAM, S_DRAIN} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0]  n_q;
    logic [LAG_W-1:0]   lag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic [15:0]        x_q;
    logic [15:0]        xl_q;
    logic               pv_q;
    logic               clr_q;
    logic               ld_q;
    logic               fd_q;

    logic [15:0]        mem_q [FRAME_LEN];

    logic [ADDR_W-1:0]  lag_ext_d;
    logic [ADDR_W-1:0]  n_next_d;
    logic [ADDR_W-1:0]  rd_a_d;
    logic [ADDR_W-1:0]  rd_b_d;
    logic               wr_en_d;

    // Reset wins over a coincident handshake, so the sample is never stored.
    assign wr_en_d = (state_q == S_LOAD) && sample_valid_i && !reset_i;

    always_ff @(posedge clk_i) begin
        if (wr_en_d) begin
            mem_q[wr_ptr_q] <= sample_in_i;
        end
    end

    // Read addresses for the pair presented next cycle: the first pair of a
    // lag is (buf[lag], buf[0]); later pairs advance both by one.
    always_comb begin
        lag_ext_d = ADDR_W'(lag_q);
        n_next_d  = n_q + 1'b1;
        rd_a_d    = n_next_d;
        rd_b_d    = n_next_d - lag_ext_d;
        if (state_q == S_CLEAR) begin
            rd_a_d = lag_ext_d;
            rd_b_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= '0;
            n_q      <= '0;
            lag_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            x_q      <= '0;
            xl_q     <= '0;
            pv_q     <= 1'b0;
            clr_q    <= 1'b0;
            ld_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            ld_q  <= 1'b0;
            fd_q  <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (sample_valid_i) begin
                        if (wr_ptr_q == LAST_IDX) begin
                            state_q <= S_CLEAR;
                            ready_q <= 1'b0;
                            lag_q   <= '0;
                            clr_q   <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    x_q     <= mem_q[rd_a_d];
                    xl_q    <= mem_q[rd_b_d];
                    pv_q    <= 1'b1;
                    n_q     <= lag_ext_d;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (n_q == LAST_IDX) begin
                        // Zero data after the last pair keeps the enable-less MAD steady.
                        x_q     <= '0;
                        xl_q    <= '0;
                        pv_q    <= 1'b0;
                        cnt_q   <= CNT_W'(1);
                        ld_q    <= (MAD_LAT == 1);
                        fd_q    <= (MAD_LAT == 1) && (lag_q == ORDER_C);
                        state_q <= S_DRAIN;
                    end else begin
                        x_q  <= mem_q[rd_a_d];
                        xl_q <= mem_q[rd_b_d];
                        n_q  <= n_next_d;
                    end
                end
                S_DRAIN: begin
                    // The cycle showing lag_done doubles as the CLEAR decision cycle.
                    if (ld_q) begin
                        if (lag_q == ORDER_C) begin
                            state_q  <= S_LOAD;
                            ready_q  <= 1'b1;
                            wr_ptr_q <= '0;
                            lag_q    <= '0;
                        end else begin
                            lag_q   <= lag_q + 1'b1;
                            clr_q   <= 1'b1;
                            state_q <= S_CLEAR;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == LAT_C) begin
                            ld_q <= 1'b1;
                            fd_q <= (lag_q == ORDER_C);
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign sample_ready_o = ready_q;
    assign x_o            = x_q;
    assign x_lagged_o     = xl_q;
    assign pair_valid_o   = pv_q;
    assign mad_clear_o    = clr_q;
    assign lag_idx_o      = lag_q;
    assign lag_done_o     = ld_q;
    assign frame_done_o   = fd_q;

endmodule

// File: tb/tb_autocorrelation_feeder.sv
// tb/tb_autocorrelation_feeder.sv - randomized scoreboard bench for autocorrelation_feeder
module tb_autocorrelation_feeder;

    localparam int F    = 160;
    localparam int ORD  = 10;
    localparam int LAT  = 2;
    localparam int AW   = 8;
    localparam int LW   = 4;
    localparam int NFR  = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [15:0]   sample_in_i = '0;
    logic          sample_valid_i = 1'b0;
    logic          sample_ready_o;
    logic [15:0]   x_o;
    logic [15:0]   x_lagged_o;
    logic          pair_valid_o;
    logic          mad_clear_o;
    logic [LW-1:0] lag_idx_o;
    logic          lag_done_o;
    logic          frame_done_o;

    always #5 clk = ~clk;

    autocorrelation_feeder #(
        .FRAME_LEN(F), .ORDER(ORD), .MAD_LAT(LAT), .ADDR_W(AW), .LAG_W(LW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .sample_in_i(sample_in_i),
        .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
        .x_o(x_o), .x_lagged_o(x_lagged_o), .pair_valid_o(pair_valid_o),
        .mad_clear_o(mad_clear_o), .lag_idx_o(lag_idx_o), .lag_done_o(lag_done_o),
        .frame_done_o(frame_done_o)
    );

    typedef struct {
        int          lag;
        logic [15:0] x;
        logic [15:0] xl;
    } pair_t;

    typedef struct {
        int     lag;
        longint r;
        bit     last;
    } res_t;

    pair_t       pq[$];
    res_t        rq[$];
    logic [15:0] fr[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_done = 0;
    int fr_cnt = 0;
    int last_acc_cyc = -10;
    int clr_cyc = 0;
    int first_clr = 0;
    int ready_chk_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every lag's pair list and R[k] = sum x[n]*x[n-k], from the frame contents.
    function automatic void push_frame(input logic [15:0] f[$]);
        for (int k = 0; k <= ORD; k++) begin
            longint r = 0;
            for (int n = k; n < F; n++) begin
                pair_t p;
                p.lag = k;
                p.x   = f[n];
                p.xl  = f[n-k];
                pq.push_back(p);
                r += longint'($signed(f[n])) * longint'($signed(f[n-k]));
            end
            rq.push_back('{lag: k, r: r, last: (k == ORD)});
        end
    endfunction

    // Behavioural MAD: product stage then accumulate, cleared by mad_clear.
    longint p_q = 0;
    longint acc_q = 0;
    always @(posedge clk) begin
        if (reset_i || mad_clear_o) begin
            p_q   <= 0;
            acc_q <= 0;
        end else begin
            p_q   <= longint'($signed(x_o)) * longint'($signed(x_lagged_o));
            acc_q <= acc_q + p_q;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pair or a result.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (pair_valid_o) begin
                chk("ready_low_in_stream", longint'(sample_ready_o), 0);
                if (pq.size() == 0) begin
                    chk("pair_unexpected", longint'(pair_valid_o), 0);
                end else begin
                    pair_t e;
                    e = pq.pop_front();
                    chk("pair_x", longint'(x_o), longint'(e.x));
                    chk("pair_x_lagged", longint'(x_lagged_o), longint'(e.xl));
                    chk("pair_lag_idx", longint'(lag_idx_o), longint'(e.lag));
                end
            end else begin
                chk("idle_data_zero", longint'({x_o, x_lagged_o}), 0);
            end
            chk("frame_done_align", longint'(frame_done_o && !lag_done_o), 0);
            if (mad_clear_o) begin
                clr_cyc = cyc;
                if (lag_idx_o == 0) begin
                    first_clr = cyc;
                    chk("first_clear_latency", longint'(cyc - last_acc_cyc), 1);
                end
            end
            if (lag_done_o) begin
                if (rq.size() == 0) begin
                    chk("lag_done_unexpected", longint'(lag_done_o), 0);
                end else begin
                    res_t e;
                    e = rq.pop_front();
                    chk("r_value", acc_q, e.r);
                    chk("done_lag_idx", longint'(lag_idx_o), longint'(e.lag));
                    chk("frame_done", longint'(frame_done_o), longint'(e.last));
                    chk("lag_period", longint'(cyc - clr_cyc), longint'(F - e.lag + LAT));
                    if (e.last) begin
                        chk("frame_span", longint'(cyc - first_clr + 1), 1738);
                        ready_chk_cyc = cyc + 1;
                        frames_done++;
                    end
                end
            end
            if (cyc == ready_chk_cyc) begin
                chk("ready_after_frame", longint'(sample_ready_o), 1);
            end
        end
    end

    // Driver: randomized samples, several valid patterns, one mid-stream reset.
    initial begin
        int guard = 0;
        int rst_phase = 0;
        bit v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", longint'(sample_ready_o), 1);
        chk("rst_pair_valid", longint'(pair_valid_o), 0);
        chk("rst_data", longint'({x_o, x_lagged_o}), 0);
        chk("rst_ctrl", longint'({mad_clear_o, lag_done_o, frame_done_o}), 0);
        chk("rst_lag_idx", longint'(lag_idx_o), 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        while (frames_done < NFR && guard < 40000) begin
            guard++;
            case (fr_cnt)
                0:       v = ($urandom_range(0, 1) == 1);
                1:       v = (cyc % 3 == 0);
                3:       v = 1'b1;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            sample_valid_i = v;
            sample_in_i    = 16'($urandom);
            if (rst_phase == 1) begin
                reset_i = 1'b1;
                pq.delete();
                rq.delete();
                fr.delete();
                rst_phase = 2;
            end else if (rst_phase == 2) begin
                reset_i        = 1'b1;
                sample_valid_i = 1'b1;
                rst_phase      = 3;
            end else if (rst_phase == 3) begin
                reset_i   = 1'b0;
                rst_phase = 4;
            end
            @(negedge clk);
            if (rst_phase == 3) begin
                chk("midrst_pair_valid", longint'(pair_valid_o), 0);
                chk("midrst_x", longint'(x_o), 0);
                chk("midrst_ready", longint'(sample_ready_o), 1);
                chk("midrst_lag_idx", longint'(lag_idx_o), 0);
                chk("midrst_lag_done", longint'(lag_done_o), 0);
            end
            if (!reset_i) begin
                if (fr.size() > 0) begin
                    chk("ready_during_load", longint'(sample_ready_o), 1);
                end
                if (sample_valid_i && sample_ready_o) begin
                    fr.push_back(sample_in_i);
                    last_acc_cyc = cyc;
                    if (fr.size() == F) begin
                        push_frame(fr);
                        fr.delete();
                        fr_cnt++;
                    end
                end
                if (rst_phase == 0 && fr_cnt == 2 && pair_valid_o && lag_idx_o == 1) begin
                    rst_phase = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        sample_valid_i = 1'b0;
        chk("frames_completed", longint'(frames_done), NFR);
        chk("reset_exercised", longint'(rst_phase), 4);
        chk("pair_queue_empty", longint'(pq.size()), 0);
        chk("result_queue_empty", longint'(rq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
